// File: rtl/alu_out_arbiter_pkg.sv
// Shared definitions for the ALU output arbiter: state encoding, requester
// count, one-hot source codes and the round-robin pick helper.
package alu_out_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  localparam int NUM_REQ = 4;

  localparam logic [3:0] SRC1 = 4'b0001;
  localparam logic [3:0] SRC2 = 4'b0010;
  localparam logic [3:0] SRC3 = 4'b0100;
  localparam logic [3:0] SRC4 = 4'b1000;

  // Requester 4 counts as the last winner out of reset, so requester 1 leads.
  localparam logic [3:0] LAST_RESET = SRC4;

  // One-hot round-robin pick: search starts just after the last winner and
  // wraps, so the last winner itself is considered last.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [3:0] last);
    logic [3:0] gnt;
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    gnt   = '0;
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last[i]) idx = 2'(i);
    end
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = idx + 2'(i);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/alu_out_arbiter_mux.sv
// MUX4x1: one-hot selected 4-input multiplexer; an all-zero select gives zero.
module MUX4x1 #(
  parameter int WIDTH = 8
) (
  input  logic             Sel1,
  input  logic             Sel2,
  input  logic             Sel3,
  input  logic             Sel4,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  input  logic [WIDTH-1:0] IN4,
  output logic [WIDTH-1:0] OUT
);

  // AND-OR selection; at most one select is ever high.
  always_comb begin
    OUT = ({WIDTH{Sel1}} & IN1) |
          ({WIDTH{Sel2}} & IN2) |
          ({WIDTH{Sel3}} & IN3) |
          ({WIDTH{Sel4}} & IN4);
  end

endmodule

// File: rtl/alu_out_arbiter.sv
// Four-requester round-robin arbiter feeding a single registered output slot
// with a valid/ready handshake to the consumer.
module alu_out_arbiter
  import alu_out_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int NUM_REQ    = alu_out_arbiter_pkg::NUM_REQ
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ1,
  input  logic                  REQ2,
  input  logic                  REQ3,
  input  logic                  REQ4,
  input  logic [DATA_WIDTH-1:0] DATA1,
  input  logic [DATA_WIDTH-1:0] DATA2,
  input  logic [DATA_WIDTH-1:0] DATA3,
  input  logic [DATA_WIDTH-1:0] DATA4,
  input  logic [NUM_REQ-1:0]    REQ_MASK,
  output logic                  GNT1,
  output logic                  GNT2,
  output logic                  GNT3,
  output logic                  GNT4,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  output logic [NUM_REQ-1:0]    OUT_SRC,
  input  logic                  OUT_READY
);

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [NUM_REQ-1:0]      last_q;
  logic [NUM_REQ-1:0]      src_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [NUM_REQ-1:0]      active;
  logic [NUM_REQ-1:0]      gnt;
  logic                    slot_free;
  logic                    xfer;
  logic [DATA_WIDTH-1:0]   mux_out;

  assign active    = {REQ4, REQ3, REQ2, REQ1} & REQ_MASK;
  assign slot_free = (state_q == EMPTY) || ((state_q == FULL) && OUT_READY);
  assign xfer      = |gnt;

  // Grant only when the slot can take a word and reset is not asserted.
  always_comb begin
    gnt = '0;
    if (RST && slot_free) begin
      gnt = rr_pick(active, last_q);
    end
  end

  assign GNT1 = gnt[0];
  assign GNT2 = gnt[1];
  assign GNT3 = gnt[2];
  assign GNT4 = gnt[3];

  MUX4x1 #(
    .WIDTH(DATA_WIDTH)
  ) u_mux (
    .Sel1 (gnt[0]),
    .Sel2 (gnt[1]),
    .Sel3 (gnt[2]),
    .Sel4 (gnt[3]),
    .IN1  (DATA1),
    .IN2  (DATA2),
    .IN3  (DATA3),
    .IN4  (DATA4),
    .OUT  (mux_out)
  );

  // Slot occupancy: fill on any transfer, drain when taken without a refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (OUT_READY && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output word, its source and the round-robin pointer move only on a transfer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q <= '0;
      src_q  <= '0;
      last_q <= LAST_RESET;
    end else if (xfer) begin
      data_q <= mux_out;
      src_q  <= gnt;
      last_q <= gnt;
    end
  end

  assign OUT_DATA  = data_q;
  assign OUT_SRC   = src_q;
  assign OUT_VALID = (state_q == FULL);

endmodule

// File: tb/tb_alu_out_arbiter.sv
// Scoreboard bench for alu_out_arbiter: directed scenarios plus a random phase,
// checked against a behavioural model of the round-robin output slot.
module tb_alu_out_arbiter;

  typedef struct {
    logic [7:0] d;
    logic [3:0] s;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ready;
  logic [7:0] dat [4];

  logic       gnt1, gnt2, gnt3, gnt4;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] out_src;

  int total = 0;
  int bad   = 0;

  sb_entry_t  sb[$];
  bit         mvalid = 1'b0;
  int         mlast  = 4;
  logic [7:0] mdata  = 8'h00;
  logic [3:0] msrc   = 4'h0;

  alu_out_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .REQ1      (req[0]),
    .REQ2      (req[1]),
    .REQ3      (req[2]),
    .REQ4      (req[3]),
    .DATA1     (dat[0]),
    .DATA2     (dat[1]),
    .DATA3     (dat[2]),
    .DATA4     (dat[3]),
    .REQ_MASK  (mask),
    .GNT1      (gnt1),
    .GNT2      (gnt2),
    .GNT3      (gnt3),
    .GNT4      (gnt4),
    .OUT_DATA  (out_data),
    .OUT_VALID (out_valid),
    .OUT_SRC   (out_src),
    .OUT_READY (ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] mk,
                               input logic rd, input logic [31:0] dpack);
    @(posedge clk);
    #1;
    rst_n  = r;
    req    = rq;
    mask   = mk;
    ready  = rd;
    dat[0] = dpack[7:0];
    dat[1] = dpack[15:8];
    dat[2] = dpack[23:16];
    dat[3] = dpack[31:24];
  endtask

  // Model: requester number (1..4) winning this cycle, 0 if none.
  function automatic int pickWinner();
    int cand;
    if (!rst_n) return 0;
    if (mvalid && !ready) return 0;
    for (int i = 1; i <= 4; i++) begin
      cand = ((mlast + i - 1) % 4) + 1;
      if (req[cand-1] && mask[cand-1]) return cand;
    end
    return 0;
  endfunction

  function automatic logic [3:0] expGnt();
    int k;
    k = pickWinner();
    if (k == 0) return 4'b0000;
    return 4'(1 << (k - 1));
  endfunction

  // Reference model advances at each edge and queues every word it predicts.
  always @(posedge clk) begin
    int k;
    sb_entry_t e;
    if (!rst_n) begin
      mvalid = 1'b0;
      mlast  = 4;
      mdata  = 8'h00;
      msrc   = 4'h0;
      sb.delete();
    end else begin
      k = pickWinner();
      if (k != 0) begin
        e.d = dat[k-1];
        e.s = 4'(1 << (k - 1));
        sb.push_back(e);
        mvalid = 1'b1;
        mlast  = k;
        mdata  = e.d;
        msrc   = e.s;
      end else if (mvalid && ready) begin
        mvalid = 1'b0;
      end
    end
  end

  // Monitor: mid-cycle checks of grants and held outputs, scoreboard pop on handshake.
  always @(negedge clk) begin
    sb_entry_t e;
    checkOutput("gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, {28'd0, expGnt()});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
    checkOutput("out_data_hold", {24'd0, out_data}, {24'd0, mdata});
    checkOutput("out_src_hold", {28'd0, out_src}, {28'd0, msrc});
    if (rst_n && out_valid && ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_pop: got word %0h with empty queue at %0t", out_data, $time);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_data", {24'd0, out_data}, {24'd0, e.d});
        checkOutput("sb_src", {28'd0, out_src}, {28'd0, e.s});
      end
    end
  end

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n = 1'b0; req = 4'b0001; mask = 4'hF; ready = 1'b1;
    dat[0] = 8'h00; dat[1] = 8'h00; dat[2] = 8'h00; dat[3] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h0);
    checkOutput("reset_valid", {31'd0, out_valid}, 32'h0);
    checkOutput("reset_data", {24'd0, out_data}, 32'h0);
    checkOutput("reset_src", {28'd0, out_src}, 32'h0);

    // Single request after reset, then drain without refill.
    applyStimulus(1'b1, 4'b0010, 4'hF, 1'b1, 32'h0000_A500);
    @(negedge clk);
    checkOutput("single_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h2);
    applyStimulus(1'b1, 4'b0000, 4'hF, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("single_data", {24'd0, out_data}, 32'hA5);
    checkOutput("single_src", {28'd0, out_src}, 32'h2);
    checkOutput("single_valid", {31'd0, out_valid}, 32'h1);
    applyStimulus(1'b1, 4'b0000, 4'hF, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("drain_valid", {31'd0, out_valid}, 32'h0);
    checkOutput("drain_data", {24'd0, out_data}, 32'hA5);

    // All four requesting after reset: 1,2,3,4,1 back-to-back.
    applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'hF, 1'b1, 32'h4433_2211);
      @(negedge clk);
      checkOutput("rr_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, {28'd0, order[i]});
      if (i > 0) checkOutput("rr_valid", {31'd0, out_valid}, 32'h1);
    end

    // Backpressure: word from requester 1 held while REQ3 waits.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b0100, 4'hF, 1'b0, 32'h4433_2211);
      @(negedge clk);
      checkOutput("bp_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h0);
      checkOutput("bp_data", {24'd0, out_data}, 32'h11);
      checkOutput("bp_src", {28'd0, out_src}, 32'h1);
    end
    applyStimulus(1'b1, 4'b0100, 4'hF, 1'b1, 32'h4433_2211);
    @(negedge clk);
    checkOutput("bp_release_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h4);

    // Masking: REQ3 hidden, then unmasked with LAST=4.
    applyStimulus(1'b1, 4'b1100, 4'b1011, 1'b1, 32'h4433_2211);
    @(negedge clk);
    checkOutput("mask_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h8);
    applyStimulus(1'b1, 4'b1100, 4'b1111, 1'b1, 32'h4433_2211);
    @(negedge clk);
    checkOutput("unmask_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h4);

    // Reset while holding 8'h3C, then REQ1/REQ2 pair.
    applyStimulus(1'b1, 4'b0001, 4'hF, 1'b1, 32'h0000_003C);
    applyStimulus(1'b0, 4'b0000, 4'hF, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("pre_reset_data", {24'd0, out_data}, 32'h3C);
    applyStimulus(1'b1, 4'b0011, 4'hF, 1'b1, 32'h0000_BBAA);
    @(negedge clk);
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'h0);
    checkOutput("midrst_data", {24'd0, out_data}, 32'h0);
    checkOutput("midrst_src", {28'd0, out_src}, 32'h0);
    checkOutput("midrst_gnt", {28'd0, gnt4, gnt3, gnt2, gnt1}, 32'h1);

    // Random traffic with occasional masks, stalls and resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                    ($urandom_range(0, 3) != 0),
                    $urandom);
    end

    repeat (3) applyStimulus(1'b1, 4'b0000, 4'hF, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_out_arbiter.md
ALU_OUT_ARBITER -- requirements
Module: alu_out_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of every data port.
REQ-002 SHALL have parameter NUM_REQ, default 4, the requester count, fixed at 4 and not overridable.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have ports REQ1..REQ4, input, 1 each, requester n has data to transfer.
REQ-006 SHALL have ports DATA1..DATA4, input, DATA_WIDTH each, requester n payload, valid while REQn=1.
REQ-007 SHALL have port REQ_MASK, input, 4, per-requester enable; bit n-1=0 makes REQn ignored.
REQ-008 SHALL have ports GNT1..GNT4, output, 1 each, combinational; transfer from requester n occurs in any cycle with REQn=1 and GNTn=1.
REQ-009 SHALL have port OUT_DATA, output, DATA_WIDTH, registered payload of the current winner.
REQ-010 SHALL have port OUT_VALID, output, 1, registered; OUT_DATA holds an untaken word.
REQ-011 SHALL have port OUT_SRC, output, 4, registered one-hot source of OUT_DATA ({1,2,3,4} maps to bits 0..3).
REQ-012 SHALL have port OUT_READY, input, 1, consumer accepts OUT_DATA in any cycle with OUT_VALID=1 and OUT_READY=1.

Function
REQ-013 SHALL be a two-state machine: EMPTY, meaning the output register is free, and FULL, meaning OUT_VALID=1.
REQ-014 SHALL compute SLOT_FREE = (state==EMPTY) or (state==FULL and OUT_READY=1).
REQ-015 SHALL assert at most one GNTn per cycle, and only when SLOT_FREE=1, RST=1, REQn=1 and REQ_MASK[n-1]=1.
REQ-016 SHALL pick the winner round-robin from pointer LAST: priority order is LAST+1, LAST+2, and so on, wrapping 4->1, with LAST checked last.
REQ-017 SHALL on a transfer from requester k at edge t: load OUT_DATA=DATAk, set OUT_SRC bit k-1, OUT_VALID=1, LAST=k, state FULL; all visible at t+1, giving latency 1 cycle.
REQ-018 SHALL in FULL with OUT_READY=1 and no grant: clear OUT_VALID, go to EMPTY, and hold OUT_DATA and OUT_SRC unchanged.
REQ-019 SHALL in FULL with OUT_READY=1 and a grant: replace the word back-to-back with OUT_VALID staying 1, giving throughput 1 word/cycle.
REQ-020 SHALL in FULL with OUT_READY=0: hold OUT_DATA, OUT_SRC, OUT_VALID and LAST, and assert no GNT.
REQ-021 SHALL leave LAST unchanged in cycles with no transfer; masked or idle requesters do not move the pointer.
REQ-022 SHALL have mask changes take effect in the same cycle (combinational) and never alter an already-loaded word.
REQ-023 SHALL be fair: a continuously requesting unmasked requester is granted within 4 transfers.
REQ-024 SHALL have OUT_SRC one-hot whenever OUT_VALID=1, and all-zero only after reset before the first transfer.

Reset
REQ-025 SHALL, while RST=0 at a rising edge, set state=EMPTY, OUT_VALID=0, OUT_DATA=0, OUT_SRC=4'b0000, LAST=4 so requester 1 has top priority.
REQ-026 SHALL force GNT1..GNT4 to 0 while RST=0.
REQ-027 SHALL on reset during FULL discard the held word without signalling; the consumer sees OUT_VALID fall.

Structure
REQ-028 SHALL take from a shared package: state encoding (EMPTY/FULL), NUM_REQ=4, LAST reset value 4, and the one-hot source constants.
REQ-029 SHALL use the existing MUX4x1 block as its one sub-module: the grant vector drives Sel1..Sel4 and DATA1..DATA4 drive IN1..IN4.
REQ-030 SHALL take the output register's load value from the MUX4x1 output.
REQ-031 SHALL contain no other sub-modules.

Verification
REQ-032 SHALL cover single request after reset: REQ2=1, DATA2=8'hA5, OUT_READY=1.
- GNT2=1 in the same cycle.
- Next cycle: OUT_DATA=8'hA5, OUT_SRC=4'b0010, OUT_VALID=1.
REQ-033 SHALL cover simultaneous requests after reset: REQ1..REQ4=1 held, OUT_READY=1.
- Grant order is 1,2,3,4,1.
- One word per cycle; OUT_VALID stays 1.
REQ-034 SHALL cover backpressure: OUT_READY=0 for 5 cycles with REQ3=1.
- OUT_DATA and OUT_SRC stable; GNT3=0 all 5 cycles.
- OUT_READY=1 gives GNT3=1 that same cycle.
REQ-035 SHALL cover masking: REQ_MASK=4'b1011, REQ3=1, REQ4=1.
- Only GNT4 asserts.
- Clearing the mask to 4'b1111 next grants 3, since LAST=4.
REQ-036 SHALL cover mid-operation reset: RST=0 for one edge while FULL with 8'h3C.
- Next cycle: OUT_VALID=0, OUT_DATA=0, OUT_SRC=0.
- A subsequent REQ1/REQ2 pair grants 1 first.
REQ-037 SHALL cover drain without refill: FULL, OUT_READY=1, no requests.
- Next cycle: OUT_VALID=0, with OUT_DATA unchanged.
